// File: rtl/alu_result_sel.sv
// alu_result_sel
//   Registered result selector for the ALU back end. One source channel out
//   of NUM_SRC is picked by opcode, registered together with its zero/sign
//   flags and a bad-opcode marker, and handed to the consumer through a
//   valid/ready handshake.
//
//   Optional build macro: ALU_RESULT_SEL_SKID_EN
//     undefined : single output register, in_ready = !out_valid || out_ready
//     defined   : 2-entry skid buffer in front of the consumer, in_ready is
//                 registered and means "buffer not full"
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     in_valid   opcode/src_bus valid this cycle
//     in_ready   block accepts a request this cycle
//     opcode     source select (SEL_W bits)
//     src_bus    packed sources, channel k = src_bus[k*WIDTH +: WIDTH]
//     out_valid  zout and flags hold a valid result
//     out_ready  consumer accepts the result
//     zout       selected result (registered)
//     zero_flag  zout == 0
//     sign_flag  zout[WIDTH-1]
//     bad_op     result came from opcode >= NUM_SRC
//     op_count   number of accepted requests, wraps at 16 bits
module alu_result_sel #(
    parameter int WIDTH   = 8,
    parameter int NUM_SRC = 16,
    parameter int SEL_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         opcode,
    input  logic [NUM_SRC*WIDTH-1:0] src_bus,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         zout,
    output logic                     zero_flag,
    output logic                     sign_flag,
    output logic                     bad_op,
    output logic [15:0]              op_count
);

    if ((2 ** SEL_W) < NUM_SRC) begin : g_bad_param
        $error("alu_result_sel: SEL_W too narrow for NUM_SRC");
    end

    localparam logic [SEL_W:0] NUM_SRC_L = (SEL_W + 1)'(NUM_SRC);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_zout;
    logic             r_zero;
    logic             r_sign;
    logic             r_bad;
    logic [15:0]      r_op_count;

    logic             w_bad;
    logic [WIDTH-1:0] w_sel;
    logic             w_accept;
    logic             w_retire;
    logic             w_load_new;
    logic             w_load_sk;
    logic             w_ov_nxt;
    logic [WIDTH-1:0] w_ld_data;
    logic             w_ld_bad;

    // Select stage: out-of-range opcodes match no channel and yield zero.
    assign w_bad = ({1'b0, opcode} >= NUM_SRC_L);

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (opcode == SEL_W'(k)) begin
                w_sel = src_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_accept = in_valid && in_ready;
    assign w_retire = r_out_valid && out_ready;

`ifdef ALU_RESULT_SEL_SKID_EN
    // Output register is the FIFO head; r_sk_* holds the second entry.
    logic [1:0]       r_cnt;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_sk_data;
    logic             r_sk_bad;
    logic [1:0]       w_cnt_nxt;

    assign in_ready   = r_in_ready;
    assign w_cnt_nxt  = r_cnt + {1'b0, w_accept} - {1'b0, w_retire};
    // New request goes straight to the head when the head is (or becomes) free.
    assign w_load_new = w_accept && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_retire));
    // Head retires while the skid slot is occupied: promote the skid entry.
    assign w_load_sk  = w_retire && (r_cnt == 2'd2);
    assign w_ld_data  = w_load_new ? w_sel : r_sk_data;
    assign w_ld_bad   = w_load_new ? w_bad : r_sk_bad;
    assign w_ov_nxt   = (w_cnt_nxt != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_in_ready <= (w_cnt_nxt != 2'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && (r_cnt == 2'd1) && !w_retire) begin
            r_sk_data <= w_sel;
            r_sk_bad  <= w_bad;
        end
    end
`else
    assign in_ready   = !r_out_valid || out_ready;
    assign w_load_new = w_accept;
    assign w_load_sk  = 1'b0;
    assign w_ld_data  = w_sel;
    assign w_ld_bad   = w_bad;
    assign w_ov_nxt   = w_accept || (r_out_valid && !out_ready);
`endif

    // Output stage: flags are computed from the very data being loaded so
    // they are always coherent with zout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_zout      <= '0;
            r_zero      <= 1'b1;
            r_sign      <= 1'b0;
            r_bad       <= 1'b0;
        end else begin
            r_out_valid <= w_ov_nxt;
            if (w_load_new || w_load_sk) begin
                r_zout <= w_ld_data;
                r_zero <= (w_ld_data == '0);
                r_sign <= w_ld_data[WIDTH-1];
                r_bad  <= w_ld_bad;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= 16'd0;
        end else if (w_accept) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign out_valid = r_out_valid;
    assign zout      = r_zout;
    assign zero_flag = r_zero;
    assign sign_flag = r_sign;
    assign bad_op    = r_bad;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_result_sel.sv
// tb_alu_result_sel
//   Randomized bench for alu_result_sel with a queue-based reference model.
//   Main instance: WIDTH=8, NUM_SRC=12, SEL_W=4 (opcodes 12..15 are bad).
//   Second instance: WIDTH=32, NUM_SRC=4, SEL_W=2.
module tb_alu_result_sel;
    localparam int W = 8;
    localparam int N = 12;
    localparam int S = 4;
`ifdef ALU_RESULT_SEL_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           in_valid, in_ready, out_valid, out_ready;
    logic [S-1:0]   opcode;
    logic [N*W-1:0] src_bus;
    logic [W-1:0]   zout;
    logic           zero_flag, sign_flag, bad_op;
    logic [15:0]    op_count;

    logic           v32, rdy32, ov32, ordy32, zf32, sf32, bad32;
    logic [1:0]     op32;
    logic [127:0]   bus32;
    logic [31:0]    z32;
    logic [15:0]    cnt32;

    alu_result_sel #(.WIDTH(W), .NUM_SRC(N), .SEL_W(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .src_bus(src_bus), .out_valid(out_valid),
        .out_ready(out_ready), .zout(zout), .zero_flag(zero_flag),
        .sign_flag(sign_flag), .bad_op(bad_op), .op_count(op_count)
    );

    alu_result_sel #(.WIDTH(32), .NUM_SRC(4), .SEL_W(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32),
        .opcode(op32), .src_bus(bus32), .out_valid(ov32),
        .out_ready(ordy32), .zout(z32), .zero_flag(zf32),
        .sign_flag(sf32), .bad_op(bad32), .op_count(cnt32)
    );

    typedef struct {
        logic [W-1:0] z;
        logic         bad;
    } res_t;

    res_t        q[$];
    res_t        last;
    logic [15:0] m_cnt;
    int          errs = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: opcode beyond the channel count gives a zero, flagged result;
    // otherwise the channel is the opcode-th W-bit slice of the bus.
    function automatic res_t ref_model(input int op, input logic [N*W-1:0] bus);
        res_t r;
        if (op >= N) begin
            r.z   = '0;
            r.bad = 1'b1;
        end else begin
            r.z   = W'(bus >> (op * W));
            r.bad = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [N*W-1:0] rand_bus();
        logic [N*W-1:0] b;
        for (int i = 0; i < N; i++) b[i*W +: W] = W'($urandom);
        return b;
    endfunction

    task automatic check_out();
        check("out_valid", out_valid, q.size() > 0);
        check("zout", zout, last.z);
        check("zero_flag", zero_flag, last.z == '0);
        check("sign_flag", sign_flag, last.z[W-1]);
        check("bad_op", bad_op, last.bad);
        check("op_count", op_count, m_cnt);
    endtask

    task automatic model_reset();
        q.delete();
        last.z   = '0;
        last.bad = 1'b0;
        m_cnt    = 16'd0;
    endtask

    // One clock of stimulus: drive, check in_ready, clock, update model, check outputs.
    task automatic step(input logic v, input logic [S-1:0] op,
                        input logic [N*W-1:0] bus, input logic ordy);
        logic exp_rdy, acc, ret;
        in_valid  = v;
        opcode    = op;
        src_bus   = bus;
        out_ready = ordy;
        #1;
        exp_rdy = (CAP == 2) ? (q.size() < 2) : ((q.size() == 0) || ordy);
        check("in_ready", in_ready, exp_rdy);
        acc = v && exp_rdy;
        ret = (q.size() > 0) && ordy;
        @(posedge clk);
        if (ret) void'(q.pop_front());
        if (acc) begin
            q.push_back(ref_model(int'(op), bus));
            m_cnt = m_cnt + 16'd1;
        end
        if (q.size() > 0) last = q[0];
        #1;
        check_out();
    endtask

    initial begin
        logic [N*W-1:0] b;
        in_valid = 1'b0; opcode = '0; src_bus = '0; out_ready = 1'b0;
        v32 = 1'b0; op32 = '0; bus32 = '0; ordy32 = 1'b1;
        model_reset();

        // Values forced while reset is held.
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_zout", zout, 0);
        check("rst_zero", zero_flag, 1);
        check("rst_sign", sign_flag, 0);
        check("rst_bad", bad_op, 0);
        check("rst_count", op_count, 0);
        check("rst32_zout", z32, 0);
        check("rst32_valid", ov32, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 32-bit instance: channel 0 is zero, selected with opcode 0.
        bus32 = {32'h1234_5678, 32'h8000_0001, 32'hDEAD_BEEF, 32'h0000_0000};
        op32  = 2'd0;
        v32   = 1'b1;
        #1;
        check("w32_in_ready", rdy32, 1);

        // Channel 3 = 0x80, opcode 3.
        b = rand_bus();
        b[3*W +: W] = 8'h80;
        step(1'b1, 4'd3, b, 1'b1);
        check("req034_zout", zout, 8'h80);
        check("req034_sign", sign_flag, 1);
        check("req034_zero", zero_flag, 0);
        check("req034_count", op_count, 1);
        check("w32_zout", z32, 0);
        check("w32_zero", zf32, 1);
        check("w32_sign", sf32, 0);
        check("w32_bad", bad32, 0);
        check("w32_valid", ov32, 1);
        check("w32_count", cnt32, 1);

        op32 = 2'd2;
        // Opcode 13 is beyond NUM_SRC=12.
        step(1'b1, 4'd13, rand_bus(), 1'b1);
        check("req035_zout", zout, 0);
        check("req035_bad", bad_op, 1);
        check("req035_zero", zero_flag, 1);
        check("w32_zout2", z32, 32'h8000_0001);
        check("w32_sign2", sf32, 1);
        v32 = 1'b0;

        // Consumer stalls while three requests are offered, then drains.
        for (int i = 0; i < 3; i++) step(1'b1, 4'($urandom_range(0, 11)), rand_bus(), 1'b0);
        #1;
        check("stall_in_ready", in_ready, (CAP == 2) ? 0 : 0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, rand_bus(), 1'b1);

        // Random traffic, bad opcodes included.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), rand_bus(),
                 $urandom_range(0, 2) != 0);

        // Asynchronous reset while a result is held back.
        step(1'b1, 4'd5, rand_bus(), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid", out_valid, 0);
        check("areset_zout", zout, 0);
        check("areset_zero", zero_flag, 1);
        check("areset_sign", sign_flag, 0);
        check("areset_bad", bad_op, 0);
        check("areset_count", op_count, 0);
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // 65537 back-to-back accepts: counter wraps to 1.
        for (int i = 0; i < 65537; i++) step(1'b1, 4'($urandom_range(0, 15)), rand_bus(), 1'b1);
        check("wrap_count", op_count, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/alu_result_sel.md
ALU_RESULT_SEL -- requirements
Module: alu_result_sel

Interface
REQ-001 Parameter WIDTH, default 8: data width of every source and of the result.
REQ-002 Parameter NUM_SRC, default 16: number of source channels; legal range 2..64.
REQ-003 Parameter SEL_W, default 4: opcode width; SHALL satisfy 2**SEL_W >= NUM_SRC.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port in_valid, input, 1: opcode and src_bus are valid this cycle.
REQ-007 Port in_ready, output, 1: the block accepts a request this cycle.
REQ-008 Port opcode, input, SEL_W: source select; channel k is src_bus[k*WIDTH +: WIDTH].
REQ-009 Port src_bus, input, NUM_SRC*WIDTH: packed source channels (transfer, adder, logic and compare results).
REQ-010 Port out_valid, output, 1: zout and the flags hold a valid result.
REQ-011 Port out_ready, input, 1: the consumer accepts the result.
REQ-012 Port zout, output, WIDTH: selected result, registered.
REQ-013 Port zero_flag, output, 1: zout == 0.
REQ-014 Port sign_flag, output, 1: zout[WIDTH-1].
REQ-015 Port bad_op, output, 1: the result came from opcode >= NUM_SRC.
REQ-016 Port op_count, output, 16: count of accepted requests.

Function
REQ-017 Accept condition: in_valid && in_ready; only an accepted request SHALL change result state.
REQ-018 Latency: an accepted request SHALL appear on zout/out_valid in the next cycle; no combinational path from src_bus to zout.
REQ-019 Output handshake: out_valid && out_ready retires the result; zout, flags and bad_op SHALL stay stable while out_valid && !out_ready.
REQ-020 Accepting a request with opcode >= NUM_SRC SHALL produce zout = 0, bad_op = 1, zero_flag = 1 and sign_flag = 0.
REQ-021 zero_flag and sign_flag SHALL be registered together with zout and be coherent with it in every cycle.
REQ-022 Without the skid buffer, in_ready = !out_valid || out_ready; simultaneous retire and accept SHALL load the new result with out_valid held at 1.
REQ-023 op_count SHALL increment by 1 on every accept, including bad opcodes, and wrap from 0xFFFF to 0x0000.
REQ-024 out_valid SHALL fall to 0 after a retire with no accept in the same cycle; zout SHALL keep its last value.

Reset
REQ-025 While rst_n = 0 these outputs SHALL be forced: out_valid = 0, zout = 0, zero_flag = 1, sign_flag = 0, bad_op = 0, op_count = 0, skid buffer empty.
REQ-026 Reset asserted mid-transaction SHALL discard all pending results immediately, with no output handshake.
REQ-027 in_ready SHALL be 1 in the first clock after rst_n deasserts.

Configuration
REQ-028 Macro ALU_RESULT_SEL_SKID_EN: when defined, a 2-entry skid buffer SHALL sit between the select stage and the output.
REQ-029 With ALU_RESULT_SEL_SKID_EN defined, in_ready SHALL be a register output equal to "buffer not full".
REQ-030 With ALU_RESULT_SEL_SKID_EN defined, the block SHALL sustain one accept per cycle with out_ready held high.
REQ-031 With ALU_RESULT_SEL_SKID_EN defined, the block SHALL absorb exactly one extra request after out_ready falls, with results retired in FIFO order.
REQ-032 Without ALU_RESULT_SEL_SKID_EN, REQ-022 SHALL apply and no skid storage SHALL exist.
REQ-033 Latency per REQ-018 SHALL hold in both builds when the buffer is empty.

Verification
REQ-034 WIDTH=8, NUM_SRC=16, channel 3 = 0x80, opcode=3, single accept -> next cycle zout=0x80, sign_flag=1, zero_flag=0, op_count=1.
REQ-035 NUM_SRC=12, opcode=13 accepted -> zout=0x00, bad_op=1, zero_flag=1.
REQ-036 out_ready=0 while 3 requests are offered (skid build) -> 2 accepted and in_ready=0; out_ready=1 -> results retire in order and in_ready returns to 1.
REQ-037 Back-to-back accepts for 65537 cycles with out_ready=1 -> op_count=0x0001 and one result per cycle.
REQ-038 rst_n pulled low asynchronously while out_valid=1 and out_ready=0 -> out_valid=0 and zout=0 before the next clock edge.
REQ-039 WIDTH=32, NUM_SRC=4, opcode=0 with channel 0 = 0x0000_0000 -> zout=0, zero_flag=1, sign_flag=0, bad_op=0.
